// File: rtl/instruction_issue_controller.sv
// Buffers instruction words in a small FIFO and issues them one at a time to the core.
// Optional `ISSUE_TIMEOUT_EN adds a timeout on core_busy rising after start.
module instruction_issue_controller #(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [INSTR_W-1:0]     in_instr,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   core_busy,
  output logic [INSTR_W-1:0]     core_instr,
  output logic                   core_start,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       retired_count,
`ifdef ISSUE_TIMEOUT_EN
  output logic                   timeout_err,
`endif
  output logic                   idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_EXEC} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic [INSTR_W-1:0] r_core_instr;
  logic [CNT_W-1:0]   r_retired;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_retire;
  logic               w_timeout;

  assign w_full        = (r_count == CW'(DEPTH));
  // Flush takes priority over both a push and an IDLE pop in the same cycle.
  assign w_push        = in_valid && !w_full && !flush;
  assign in_ready      = !w_full;
  assign fifo_count    = r_count;
  assign core_instr    = r_core_instr;
  assign retired_count = r_retired;
  assign idle          = (r_count == '0) && (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_instr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rptr  <= r_wptr;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_core_instr <= '0;
      r_retired    <= '0;
    end else begin
      if (w_pop)    r_core_instr <= r_mem[r_rptr];
      if (w_retire) r_retired    <= r_retired + 1'b1;
    end
  end

`ifdef ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;

  assign w_timeout = (r_state == S_WAIT_BUSY) && !core_busy &&
                     (r_to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (r_state != S_WAIT_BUSY) r_to_cnt <= '0;
      else if (!core_busy)        r_to_cnt <= r_to_cnt + 1'b1;
      if (w_timeout) timeout_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_pop) w_next = S_ISSUE;
      S_ISSUE:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (core_busy)      w_next = S_EXEC;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_EXEC:      if (!core_busy) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop      = (r_state == S_IDLE) && (r_count != '0) && !core_busy && !flush;
    core_start = (r_state == S_ISSUE);
    w_retire   = (r_state == S_EXEC) && !core_busy;
  end

endmodule

// File: tb/tb_instruction_issue_controller.sv
// Directed bench for instruction_issue_controller with a simple fixed-length core busy model.
// Narrow retired counter (CNT_W=4) so wraparound is reachable quickly.
module tb_instruction_issue_controller;
  logic        clk = 1'b0;
  logic        reset, in_valid, flush, ext_busy, model_en;
  logic [31:0] in_instr;
  logic        in_ready, core_busy, core_start, idle;
  logic [31:0] core_instr;
  logic [2:0]  fifo_count;
  logic [3:0]  retired_count;
`ifdef ISSUE_TIMEOUT_EN
  logic        timeout_err;
`endif
  int busy_len, busy_left;
  int checks = 0, errors = 0;

  instruction_issue_controller #(.INSTR_W(32), .DEPTH(4), .CNT_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush), .core_busy(core_busy), .core_instr(core_instr), .core_start(core_start),
    .fifo_count(fifo_count), .retired_count(retired_count),
`ifdef ISSUE_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .idle(idle));

  always #5 clk = ~clk;

  // Core model: busy for busy_len cycles starting the cycle after a start pulse.
  always @(posedge clk) begin
    if (reset) busy_left <= 0;
    else if (core_start && model_en) busy_left <= busy_len;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end
  assign core_busy = ext_busy || (busy_left != 0);

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset = 1; in_valid = 0; in_instr = '0; flush = 0; ext_busy = 0; model_en = 1; busy_len = 4;
    tick; tick;
    reset = 0;
  endtask

  task automatic push(input logic [31:0] w);
    in_valid = 1; in_instr = w; tick; in_valid = 0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b exp 0", core_start); end
    checks++; if (core_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", core_instr); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
    checks++; if (retired_count !== 4'd0) begin errors++; $display("FAIL rst_retired got %0d exp 0", retired_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", in_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b exp 1", idle); end
  endtask

  task automatic test_single_issue;
    int n; bit bad;
    do_reset;
    push(32'h00A00093);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", fifo_count); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL single_nofall got %b exp 0", core_start); end
    tick;
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL single_start got %b exp 1", core_start); end
    checks++; if (core_instr !== 32'h00A00093) begin errors++; $display("FAIL single_instr got %h exp 00a00093", core_instr); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_pop got %0d exp 0", fifo_count); end
    tick;
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL single_pulse got %b exp 0", core_start); end
    n = 0; bad = 0;
    while (!(idle && retired_count == 4'd1) && n < 30) begin
      if (core_instr !== 32'h00A00093 || core_start !== 1'b0) bad = 1;
      tick; n++;
    end
    checks++; if (n >= 30) begin errors++; $display("FAIL single_timeout got %0d cycles exp <30", n); end
    checks++; if (bad) begin errors++; $display("FAIL single_hold got %b exp 0", bad); end
    checks++; if (retired_count !== 4'd1) begin errors++; $display("FAIL single_retired got %0d exp 1", retired_count); end
    checks++; if (core_instr !== 32'h00A00093) begin errors++; $display("FAIL single_retain got %h exp 00a00093", core_instr); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w [5];
    int idx, n; bit accept;
    w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444; w[4] = 32'h55555555;
    do_reset;
    ext_busy = 1;
    for (int i = 0; i < 4; i++) begin in_valid = 1; in_instr = w[i]; tick; end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_full got %0d exp 4", fifo_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got %b exp 0", in_ready); end
    in_instr = w[4]; tick;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_held got %0d exp 4", fifo_count); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL b2b_extbusy got %b exp 0", core_start); end
    ext_busy = 0;
    idx = 0; n = 0;
    while (!(idle && retired_count == 4'd5) && n < 120) begin
      accept = in_valid && in_ready;
      tick; n++;
      if (accept) in_valid = 0;
      if (core_start) begin
        checks++;
        if (idx >= 5) begin errors++; $display("FAIL b2b_extra got %h exp none", core_instr); end
        else if (core_instr !== w[idx]) begin errors++; $display("FAIL b2b_order%0d got %h exp %h", idx, core_instr, w[idx]); end
        idx++;
      end
    end
    in_valid = 0;
    checks++; if (idx !== 5) begin errors++; $display("FAIL b2b_issued got %0d exp 5", idx); end
    checks++; if (retired_count !== 4'd5) begin errors++; $display("FAIL b2b_retired got %0d exp 5", retired_count); end
  endtask

  task automatic test_flush;
    int starts;
    do_reset;
    busy_len = 10;
    push(32'hA0A0A0A0); push(32'hB0B0B0B0); push(32'hC0C0C0C0); push(32'hD0D0D0D0);
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d exp 3", fifo_count); end
    flush = 1; in_valid = 1; in_instr = 32'hE0E0E0E0; tick; flush = 0; in_valid = 0;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", fifo_count); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL flush_inflight got %b exp 0", idle); end
    starts = 0;
    for (int i = 0; i < 30; i++) begin tick; if (core_start) starts++; end
    checks++; if (starts !== 0) begin errors++; $display("FAIL flush_starts got %0d exp 0", starts); end
    checks++; if (retired_count !== 4'd1) begin errors++; $display("FAIL flush_retired got %0d exp 1", retired_count); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL flush_idle got %b exp 1", idle); end
    // Flush coinciding with an IDLE pop: pop suppressed, core_instr untouched.
    push(32'hF0F0F0F0);
    flush = 1; tick; flush = 0;
    checks++; if (core_instr !== 32'hA0A0A0A0) begin errors++; $display("FAIL flushpop_instr got %h exp a0a0a0a0", core_instr); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL flushpop_cnt got %0d exp 0", fifo_count); end
    tick;
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL flushpop_start got %b exp 0", core_start); end
  endtask

  task automatic test_wrap;
    int n;
    do_reset;
    busy_len = 1;
    for (int i = 0; i < 16; i++) begin
      push(32'h100 + i);
      n = 0;
      while (!idle && n < 20) begin tick; n++; end
      checks++; if (n >= 20) begin errors++; $display("FAIL wrap_timeout%0d got %0d exp <20", i, n); end
      if (i == 14) begin
        checks++; if (retired_count !== 4'hF) begin errors++; $display("FAIL wrap_max got %0d exp 15", retired_count); end
      end
    end
    checks++; if (retired_count !== 4'h0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", retired_count); end
  endtask

  task automatic test_reset_mid_exec;
    int n;
    do_reset;
    push(32'h0000_0013);
    n = 0; while (!idle && n < 20) begin tick; n++; end
    busy_len = 10;
    push(32'hAAAA0001); push(32'hAAAA0002); push(32'hAAAA0003); tick;
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rstx_pre got %0d exp 2", fifo_count); end
    checks++; if (retired_count !== 4'd1) begin errors++; $display("FAIL rstx_preret got %0d exp 1", retired_count); end
    reset = 1; tick;
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL rstx_start got %b exp 0", core_start); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rstx_cnt got %0d exp 0", fifo_count); end
    checks++; if (retired_count !== 4'd0) begin errors++; $display("FAIL rstx_retired got %0d exp 0", retired_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstx_ready got %b exp 1", in_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rstx_idle got %b exp 1", idle); end
    checks++; if (core_instr !== 32'h0) begin errors++; $display("FAIL rstx_instr got %h exp 0", core_instr); end
    reset = 0; tick; tick;
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL rstx_after got %b exp 0", core_start); end
  endtask

`ifdef ISSUE_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    do_reset;
    model_en = 0;
    push(32'hDEAD0001);
    for (int i = 0; i < 9; i++) tick;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", timeout_err); end
    tick;
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set got %b exp 1", timeout_err); end
    checks++; if (retired_count !== 4'd0) begin errors++; $display("FAIL to_retired got %0d exp 0", retired_count); end
    model_en = 1;
    push(32'hBEEF0002);
    n = 0; while (!(idle && retired_count == 4'd1) && n < 30) begin tick; n++; end
    checks++; if (retired_count !== 4'd1) begin errors++; $display("FAIL to_next got %0d exp 1", retired_count); end
    checks++; if (core_instr !== 32'hBEEF0002) begin errors++; $display("FAIL to_instr got %h exp beef0002", core_instr); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", timeout_err); end
  endtask
`endif

  initial begin
    test_reset;
    test_single_issue;
    test_back_to_back;
    test_flush;
    test_wrap;
    test_reset_mid_exec;
`ifdef ISSUE_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
